// File: rtl/mul4su_pkg.sv
// Shared constants and the stage-1 payload type for the signed x unsigned
// multiplier scheduler.
package mul4su_pkg;

    localparam int NREQ_DEF = 4;
    localparam int OPW      = 4;
    localparam int PRODW    = 8;
    localparam int CNTW     = 16;
    // Source field is sized for the largest supported requester count; the top
    // uses only the low $clog2(NREQ) bits.
    localparam int SRC_MAXW = 8;

    typedef struct packed {
        logic [OPW-1:0]      s;
        logic [OPW-1:0]      u;
        logic [SRC_MAXW-1:0] src;
    } s1_pay_t;

endpackage

// File: rtl/mul4su_core.sv
// Exact combinational 4-bit signed x 4-bit unsigned multiplier, 8-bit signed
// product (range -120..+105, so the low 8 bits are always exact).
module mul4su_core (
    input  logic [3:0] s,
    input  logic [3:0] u,
    output logic [7:0] prod
);

    logic [7:0] s_ext;
    logic [7:0] u_ext;

    always_comb begin
        s_ext = {{4{s[3]}}, s};
        u_ext = {4'b0000, u};
        prod  = s_ext * u_ext;
    end

endmodule

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: one-hot grant plus encoded index; the priority
// pointer moves past the winner only when the grant is consumed (en).
module rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);

    logic [W-1:0] ptr;
    int unsigned  lane;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        lane      = 0;
        for (int k = 0; k < N; k++) begin
            lane = (int'(ptr) + k) % N;
            if (!grant_any && req[lane]) begin
                grant_any   = 1'b1;
                grant[lane] = 1'b1;
                grant_idx   = W'(lane);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && grant_any) begin
            ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
        end
    end

endmodule

// File: rtl/mul4su_sched.sv
// Round-robin scheduler sharing one 4x4 signed x unsigned multiplier among
// NREQ requesters through a 2-stage pipeline with a tagged response port.
module mul4su_sched
    import mul4su_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int SRCW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_s,
    input  logic [OPW*NREQ-1:0] req_u,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [PRODW-1:0]    rsp_prod,
    output logic [SRCW-1:0]     rsp_src,
    output logic                busy,
    output logic [CNTW-1:0]     done_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a held valid keeps its payload
    // stable. rsp_valid is a pure register output, so nothing combinational
    // runs from rsp_ready to rsp_valid.

    logic             s1_valid;
    s1_pay_t          s1_q;
    logic             s2_valid;
    logic [PRODW-1:0] s2_prod;
    logic [SRCW-1:0]  s2_src;

    logic             adv1;
    logic             adv2;
    logic [NREQ-1:0]  grant;
    logic [SRCW-1:0]  grant_idx;
    logic             grant_any;
    logic             accept;
    logic             arb_en;
    s1_pay_t          s1_d;
    logic [PRODW-1:0] core_prod;
    logic             unused_src_hi;

    assign adv2   = !s2_valid || rsp_ready;
    assign adv1   = !s1_valid || adv2;
    assign arb_en = adv1 && !rst;

    rr_arb #(
        .N (NREQ),
        .W (SRCW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = arb_en ? grant : '0;
    assign accept    = arb_en && grant_any;

    always_comb begin
        s1_d     = '0;
        s1_d.s   = req_s[int'(grant_idx) * OPW +: OPW];
        s1_d.u   = req_u[int'(grant_idx) * OPW +: OPW];
        s1_d.src = SRC_MAXW'(grant_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    mul4su_core u_core (
        .s    (s1_q.s),
        .u    (s1_q.u),
        .prod (core_prod)
    );

    // Stage 2 only loads when stage 1 holds a product, so a bubble leaves the
    // last response visible on rsp_prod/rsp_src.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_src   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= core_prod;
                s2_src  <= s1_q.src[SRCW-1:0];
            end
        end
    end

    assign unused_src_hi = ^s1_q.src[SRC_MAXW-1:SRCW];

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (s2_valid && rsp_ready && (done_cnt != {CNTW{1'b1}})) begin
            done_cnt <= done_cnt + CNTW'(1);
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_prod  = s2_prod;
    assign rsp_src   = s2_src;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul4su_sched.sv
// Bench for mul4su_sched: directed stimulus, expected-response queue filled at
// accept time and drained by a monitor on each response handshake.
module tb_mul4su_sched;

    localparam int NREQ = 4;
    localparam int SRCW = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_s;
    logic [4*NREQ-1:0] req_u;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_prod;
    logic [SRCW-1:0]   rsp_src;
    logic              busy;
    logic [15:0]       done_cnt;

    mul4su_sched #(.NREQ(NREQ), .SRCW(SRCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_s     (req_s),
        .req_u     (req_u),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_src   (rsp_src),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic armed = 1'b0;
    always @(posedge clk) if (rst) armed <= 1'b1;

    // ---------------- lane operands ----------------
    logic [3:0] lane_s [NREQ];
    logic [3:0] lane_u [NREQ];

    always_comb begin
        req_s = '0;
        req_u = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_s[4*i +: 4] = lane_s[i];
            req_u[4*i +: 4] = lane_u[i];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q [$];
    logic [1:0] src_log [$];
    logic [7:0] prod_log [$];
    logic [NREQ-1:0] last_acc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] s, input logic [3:0] u);
        int si;
        int p;
        si = s[3] ? int'(s) - 16 : int'(s);
        p  = si * int'(u);
        return p[7:0];
    endfunction

    // Reference pipeline occupancy, arbitration pointer and response count.
    logic        m_s1 = 1'b0;
    logic        m_s2 = 1'b0;
    int          m_ptr = 0;
    logic [15:0] m_done = '0;
    logic        hold_pend = 1'b0;
    logic [9:0]  hold_val = '0;

    always @(negedge clk) begin
        logic            m_adv1;
        logic            m_adv2;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [9:0]      e;
        if (armed) begin
            m_adv2 = !m_s2 || rsp_ready;
            m_adv1 = !m_s1 || m_adv2;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            exp_rdy = '0;
            if (!rst && m_adv1 && g >= 0) exp_rdy[g] = 1'b1;

            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
            chk("busy", 32'(busy), 32'(m_s1 | m_s2));
            chk("done_cnt", 32'(done_cnt), 32'(m_done));

            if (hold_pend && !rst) chk("rsp_stable", 32'({rsp_src, rsp_prod}), 32'(hold_val));
            hold_pend = !rst && rsp_valid && !rsp_ready;
            hold_val  = {rsp_src, rsp_prod};

            last_acc = req_valid & req_ready;

            if (rst) begin
                exp_q.delete();
                m_s1 = 1'b0;
                m_s2 = 1'b0;
                m_ptr = 0;
                m_done = '0;
            end else begin
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'({rsp_src, rsp_prod}), 32'h3ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", 32'({rsp_src, rsp_prod}), 32'(e));
                    end
                    src_log.push_back(rsp_src);
                    prod_log.push_back(rsp_prod);
                end
                if (m_s2 && rsp_ready && m_done != 16'hffff) m_done = m_done + 16'd1;
                if (m_adv2) m_s2 = m_s1;
                if (m_adv1) m_s1 = (g >= 0);
                if (m_adv1 && g >= 0) begin
                    exp_q.push_back({2'(g), ref_prod(lane_s[g], lane_u[g])});
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle; lanes that completed a handshake present fresh operands.
    task automatic step();
        cyc();
        for (int i = 0; i < NREQ; i++) begin
            if (last_acc[i]) begin
                lane_s[i] = lane_s[i] + 4'd3;
                lane_u[i] = lane_u[i] + 4'd5;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_s1 || m_s2) && n < 10) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0 || m_s1 || m_s2) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int lane);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_acc[lane] && n < 20);
        if (!last_acc[lane]) chk("accept_timeout", 32'(lane), 32'hffff);
    endtask

    // ---------------- directed tests ----------------
    logic [1:0] rr_order [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    int acc_cnt;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            lane_s[i] = 4'(i + 1);
            lane_u[i] = 4'(2 * i + 3);
        end
        cyc();
        req_valid = 4'hf;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_prod", 32'(rsp_prod), 32'd0);
        chk("reset_rsp_src", 32'(rsp_src), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done_cnt", 32'(done_cnt), 32'd0);
        req_valid = '0;
        cyc();
        rst = 1'b0;

        // Single lane 0: -8 x 15
        lane_s[0] = 4'b1000;
        lane_u[0] = 4'd15;
        req_valid = 4'b0001;
        wait_acc(0);
        req_valid = '0;
        cyc();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_prod", 32'(rsp_prod), 32'h88);
        chk("single_src", 32'(rsp_src), 32'd0);
        cyc();
        chk("single_done", 32'(done_cnt), 32'd1);

        // Exhaustive on lane 2
        do_reset();
        prod_log.delete();
        for (int p = 0; p < 256; p++) begin
            lane_s[2] = 4'(p >> 4);
            lane_u[2] = 4'(p);
            req_valid = 4'b0100;
            wait_acc(2);
        end
        drain();
        chk("exh_done", 32'(done_cnt), 32'd256);
        chk("exh_count", 32'(prod_log.size()), 32'd256);
        if (prod_log.size() == 256) begin
            chk("exh_7x15", 32'(prod_log[8'h7f]), 32'h69);
            chk("exh_m1x1", 32'(prod_log[8'hf1]), 32'hff);
            chk("exh_m8x15", 32'(prod_log[8'h8f]), 32'h88);
        end

        // All lanes continuously valid from reset
        do_reset();
        src_log.delete();
        req_valid = 4'hf;
        repeat (12) step();
        drain();
        chk("rr_count", 32'(src_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < src_log.size(); i++) chk("rr_order", 32'(src_log[i]), 32'(rr_order[i]));

        // Backpressure from an empty pipeline
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        acc_cnt = 0;
        repeat (5) begin
            step();
            acc_cnt += $countones(last_acc);
        end
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        chk("bp_ready_zero", 32'(req_ready), 32'd0);
        drain();

        // Reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        repeat (3) step();
        chk("full_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rsp_ready = 1'b1;
        src_log.delete();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        repeat (4) step();
        chk("rst_first_src", 32'(src_log.size() > 0 ? src_log[0] : 2'd3), 32'd0);

        // Saturation of done_cnt
        src_log.delete();
        prod_log.delete();
        repeat (65545) step();
        src_log.delete();
        prod_log.delete();
        drain();
        chk("sat_done", 32'(done_cnt), 32'hffff);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
